// File: rtl/sha256_pkg.sv
// Shared constants, core state codes and sequencer FSM encoding for the
// SHA-256 sequencing slice.
package sha256_pkg;

  localparam int unsigned ROUNDS  = 64;
  localparam int unsigned CHUNK_W = 512;
  localparam int unsigned HASH_W  = 256;

  localparam logic [2:0] CORE_IDLE  = 3'd0;
  localparam logic [2:0] CORE_SPARE = 3'd1;
  localparam logic [2:0] CORE_INIT  = 3'd2;
  localparam logic [2:0] CORE_CHAIN = 3'd3;
  localparam logic [2:0] CORE_LOAD  = 3'd4;
  localparam logic [2:0] CORE_ROUND = 3'd5;
  localparam logic [2:0] CORE_FINAL = 3'd6;
  localparam logic [2:0] CORE_OUT   = 3'd7;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT,
    ST_LOAD,
    ST_EXPAND,
    ST_ROUND,
    ST_FINAL,
    ST_CHAIN,
    ST_CAPTURE,
    ST_DONE
  } seq_state_t;

  // LOAD/EXPAND and CAPTURE/DONE share a code; the phase flag tells LOAD from EXPAND.
  function automatic logic [2:0] core_code(input seq_state_t s);
    case (s)
      ST_IDLE:    return CORE_IDLE;
      ST_INIT:    return CORE_INIT;
      ST_LOAD,
      ST_EXPAND:  return CORE_LOAD;
      ST_ROUND:   return CORE_ROUND;
      ST_FINAL:   return CORE_FINAL;
      ST_CHAIN:   return CORE_CHAIN;
      ST_CAPTURE,
      ST_DONE:    return CORE_OUT;
      default:    return CORE_SPARE;
    endcase
  endfunction

endpackage

// File: rtl/sha256_round_counter.sv
// Round index and phase bit: two cycles per round, index advances after
// the phase-1 cycle and wraps only after the final round.
module sha256_round_counter #(
  parameter int unsigned ROUNDS = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  output logic [5:0] indice,
  output logic       flag,
  output logic       last_round
);

  assign last_round = flag && (indice == 6'(ROUNDS - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      indice <= '0;
      flag   <= 1'b0;
    end else if (clear) begin
      indice <= '0;
      flag   <= 1'b0;
    end else if (enable) begin
      flag <= ~flag;
      if (flag) indice <= last_round ? '0 : indice + 6'd1;
    end
  end

endmodule

// File: rtl/sha256_sequencer.sv
// Sequences the SHA-256 compression core: accepts chunks, walks the core
// through init/load/expand/rounds, and returns the digest.
module sha256_sequencer #(
  parameter int unsigned ROUNDS  = 64,
  parameter int unsigned CHUNK_W = 512,
  parameter int unsigned HASH_W  = 256
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               abort,
  input  logic               in_valid,
  input  logic               in_last,
  input  logic [CHUNK_W-1:0] in_chunk,
  output logic               in_ready,
  output logic [2:0]         core_state,
  output logic [CHUNK_W-1:0] core_chunk,
  output logic               core_flag,
  output logic [5:0]         core_indice,
  output logic               core_rst_n,
  input  logic [HASH_W-1:0]  core_hash,
  output logic               out_valid,
  output logic [HASH_W-1:0]  out_hash,
  input  logic               out_ready,
  output logic               busy
);

  import sha256_pkg::*;

  seq_state_t state, next_state;
  logic       fire;
  logic       last_q;
  logic       rst_sync;
  logic       cnt_flag;
  logic       last_round;

  assign fire = in_valid && in_ready;

  sha256_round_counter #(.ROUNDS(ROUNDS)) u_cnt (
    .clock      (clock),
    .reset      (reset),
    .clear      (abort),
    .enable     (state == ST_ROUND),
    .indice     (core_indice),
    .flag       (cnt_flag),
    .last_round (last_round)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (fire) next_state = ST_INIT;
      ST_INIT:    next_state = ST_LOAD;
      ST_LOAD:    next_state = ST_EXPAND;
      ST_EXPAND:  next_state = ST_ROUND;
      ST_ROUND:   if (last_round) next_state = last_q ? ST_FINAL : ST_CHAIN;
      ST_CHAIN:   if (fire) next_state = ST_LOAD;
      ST_FINAL:   next_state = ST_CAPTURE;
      ST_CAPTURE: next_state = ST_DONE;
      ST_DONE:    if (out_ready) next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
    if (abort) next_state = ST_IDLE;
  end

  always_comb begin
    in_ready = (state == ST_IDLE || state == ST_CHAIN) && !abort && !reset;
    busy     = (state != ST_IDLE);
  end

  // Core-facing outputs are computed from next_state so they are true flops
  // that line up with the state they describe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rst_sync   <= 1'b0;
      core_rst_n <= 1'b0;
      core_state <= CORE_IDLE;
      core_flag  <= 1'b0;
      core_chunk <= '0;
      last_q     <= 1'b0;
      out_valid  <= 1'b0;
      out_hash   <= '0;
    end else begin
      rst_sync   <= 1'b1;
      core_rst_n <= rst_sync;
      core_state <= core_code(next_state);
      core_flag  <= (next_state == ST_EXPAND) ||
                    (next_state == ST_ROUND && state == ST_ROUND && !cnt_flag);
      if (fire) begin
        core_chunk <= in_chunk;
        last_q     <= in_last;
      end
      if (state == ST_CAPTURE && !abort) out_hash <= core_hash;
      out_valid <= (next_state == ST_DONE);
    end
  end

endmodule

// File: tb/tb_sha256_sequencer.sv
// Bench for sha256_sequencer: a behavioural SHA-256 core answers the
// sequencer, and a scoreboard checks each returned digest.
module tb_sha256_sequencer;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         abort = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic [511:0] in_chunk = '0;
  logic         in_ready;
  logic [2:0]   core_state;
  logic [511:0] core_chunk;
  logic         core_flag;
  logic [5:0]   core_indice;
  logic         core_rst_n;
  logic [255:0] core_hash;
  logic         out_valid;
  logic [255:0] out_hash;
  logic         out_ready = 1'b1;
  logic         busy;

  always #5 clock = ~clock;

  sha256_sequencer #(.ROUNDS(64), .CHUNK_W(512), .HASH_W(256)) dut (
    .clock       (clock),
    .reset       (reset),
    .abort       (abort),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_chunk    (in_chunk),
    .in_ready    (in_ready),
    .core_state  (core_state),
    .core_chunk  (core_chunk),
    .core_flag   (core_flag),
    .core_indice (core_indice),
    .core_rst_n  (core_rst_n),
    .core_hash   (core_hash),
    .out_valid   (out_valid),
    .out_hash    (out_hash),
    .out_ready   (out_ready),
    .busy        (busy)
  );

  localparam logic [255:0] ABC_H = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] TWO_H = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  int total = 0;
  int bad   = 0;
  int unsigned cyc = 0;
  int unsigned t_hs = 0;
  logic [255:0] exp_q [$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural SHA-256 core ----------------
  logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  logic [31:0] IV [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                          32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  logic [31:0] mh [8];
  logic [31:0] mv [8];
  logic [31:0] mw [64];
  logic        pend;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  assign core_hash = {mh[0], mh[1], mh[2], mh[3], mh[4], mh[5], mh[6], mh[7]};

  always @(posedge clock) begin
    logic [31:0] t1, t2;
    if (!core_rst_n) begin
      pend = 1'b0;
      for (int i = 0; i < 8; i++) mh[i] = '0;
    end else begin
      case (core_state)
        3'd2: for (int i = 0; i < 8; i++) mh[i] = IV[i];
        3'd4:
          if (!core_flag) begin
            for (int i = 0; i < 16; i++) mw[i] = core_chunk[511 - 32*i -: 32];
            for (int i = 0; i < 8; i++) mv[i] = mh[i];
          end else begin
            for (int i = 16; i < 64; i++)
              mw[i] = mw[i-16] + (rotr(mw[i-15], 7) ^ rotr(mw[i-15], 18) ^ (mw[i-15] >> 3))
                    + mw[i-7] + (rotr(mw[i-2], 17) ^ rotr(mw[i-2], 19) ^ (mw[i-2] >> 10));
          end
        3'd5:
          if (core_flag) begin
            t1 = mv[7] + (rotr(mv[4], 6) ^ rotr(mv[4], 11) ^ rotr(mv[4], 25))
               + ((mv[4] & mv[5]) ^ (~mv[4] & mv[6])) + KT[core_indice] + mw[core_indice];
            t2 = (rotr(mv[0], 2) ^ rotr(mv[0], 13) ^ rotr(mv[0], 22))
               + ((mv[0] & mv[1]) ^ (mv[0] & mv[2]) ^ (mv[1] & mv[2]));
            mv[7] = mv[6]; mv[6] = mv[5]; mv[5] = mv[4]; mv[4] = mv[3] + t1;
            mv[3] = mv[2]; mv[2] = mv[1]; mv[1] = mv[0]; mv[0] = t1 + t2;
            if (core_indice == 6'd63) pend = 1'b1;
          end
        3'd3, 3'd6:
          if (pend) begin
            for (int i = 0; i < 8; i++) mh[i] = mh[i] + mv[i];
            pend = 1'b0;
          end
        default: ;
      endcase
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_digest: got %0h expected none", out_hash);
      end else begin
        chk("digest", out_hash, exp_q.pop_front());
      end
    end
  end

  // ---------------- state-trace statistics ----------------
  int init_n = 0, chain_n = 0, seq_err = 0, run = 0, round_len = 0;
  always @(negedge clock) begin
    if (core_state == 3'd2) init_n++;
    if (core_state == 3'd3) chain_n++;
    if (core_state == 3'd5) begin
      if (core_indice !== 6'(run / 2) || core_flag !== run[0]) seq_err++;
      run++;
    end else if (run != 0) begin
      round_len = run;
      run = 0;
    end
  end

  task automatic clear_stats();
    init_n = 0; chain_n = 0; seq_err = 0; round_len = 0;
  endtask

  task automatic send(input logic [511:0] c, input logic last);
    int n = 0;
    @(posedge clock); #1;
    in_valid = 1'b1; in_chunk = c; in_last = last;
    @(negedge clock);
    while (!in_ready && n < 400) begin @(negedge clock); n++; end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL handshake_timeout: got in_ready=0 expected 1");
    end
    @(posedge clock); #1;
    t_hs = cyc;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_valid(output int unsigned d);
    int n = 0;
    @(negedge clock);
    while (!out_valid && n < 300) begin @(negedge clock); n++; end
    d = cyc - t_hs;
    if (!out_valid) begin
      total++; bad++;
      $display("FAIL out_valid_timeout: got 0 expected 1");
    end
  endtask

  task automatic wait_round(input int unsigned idx, input logic fl);
    int n = 0;
    @(negedge clock);
    while (!(core_state == 3'd5 && core_indice == 6'(idx) && core_flag == fl) && n < 300) begin
      @(negedge clock); n++;
    end
    if (n >= 300) begin
      total++; bad++;
      $display("FAIL round_wait_timeout: got indice=%0d expected %0d", core_indice, idx);
    end
  endtask

  initial begin
    logic [511:0] abc, c1, c2;
    logic [447:0] msg;
    logic [255:0] snap;
    int unsigned d;
    int e_v, e_h, e_r, e_b;

    abc = {24'h616263, 8'h80, 416'h0, 64'd24};
    msg = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    c1  = {msg, 8'h80, 56'h0};
    c2  = {448'h0, 64'd448};

    // reset values while reset is held
    repeat (2) @(negedge clock);
    chk("rst_in_ready", 256'(in_ready), 256'd0);
    chk("rst_core_state", 256'(core_state), 256'd0);
    chk("rst_core_chunk", 256'(core_chunk), 256'd0);
    chk("rst_core_flag", 256'(core_flag), 256'd0);
    chk("rst_core_indice", 256'(core_indice), 256'd0);
    chk("rst_core_rst_n", 256'(core_rst_n), 256'd0);
    chk("rst_out_valid", 256'(out_valid), 256'd0);
    chk("rst_out_hash", out_hash, 256'd0);
    chk("rst_busy", 256'(busy), 256'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("rel_core_rst_n_low", 256'(core_rst_n), 256'd0);
    chk("rel_in_ready", 256'(in_ready), 256'd1);
    @(posedge clock); #1;
    chk("rel_core_rst_n_high", 256'(core_rst_n), 256'd1);

    // single chunk "abc"; valid from cycle T+134, i.e. 133 edges after edge T
    clear_stats();
    exp_q.push_back(ABC_H);
    send(abc, 1'b1);
    wait_valid(d);
    chk("abc_latency", 256'(d), 256'd133);
    @(posedge clock); #1;
    @(negedge clock);
    chk("turnaround_in_ready", 256'(in_ready), 256'd1);
    chk("turnaround_busy", 256'(busy), 256'd0);
    chk("round_len", 256'(round_len), 256'd128);
    chk("round_seq_err", 256'(seq_err), 256'd0);
    chk("abc_init_once", 256'(init_n), 256'd1);
    chk("abc_no_chain", 256'(chain_n), 256'd0);

    // two-chunk message; continuation valid from T+133
    clear_stats();
    exp_q.push_back(TWO_H);
    send(c1, 1'b0);
    send(c2, 1'b1);
    wait_valid(d);
    chk("chain_latency", 256'(d), 256'd132);
    @(posedge clock); #1;
    chk("two_init_once", 256'(init_n), 256'd1);
    chk("two_chain_seen", 256'(chain_n > 0), 256'd1);
    chk("two_round_seq_err", 256'(seq_err), 256'd0);
    chk("two_round_len", 256'(round_len), 256'd128);

    // backpressure in DONE
    out_ready = 1'b0;
    exp_q.push_back(ABC_H);
    send(abc, 1'b1);
    wait_valid(d);
    snap = out_hash;
    e_v = 0; e_h = 0; e_r = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (out_valid !== 1'b1) e_v++;
      if (out_hash !== snap) e_h++;
      if (in_ready !== 1'b0) e_r++;
    end
    chk("bp_valid_held", 256'(e_v), 256'd0);
    chk("bp_hash_stable", 256'(e_h), 256'd0);
    chk("bp_in_ready_low", 256'(e_r), 256'd0);
    @(posedge clock); #1;
    out_ready = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    chk("bp_release_idle", 256'(busy), 256'd0);
    chk("bp_release_in_ready", 256'(in_ready), 256'd1);

    // abort at indice 30 with in_valid held high
    send(abc, 1'b1);
    wait_round(29, 1'b1);
    @(posedge clock); #1;
    abort = 1'b1; in_valid = 1'b1; in_chunk = abc; in_last = 1'b1;
    @(negedge clock);
    chk("abort_indice", 256'(core_indice), 256'd30);
    chk("abort_in_ready", 256'(in_ready), 256'd0);
    @(posedge clock); #1;
    abort = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    chk("abort_idle", 256'(busy), 256'd0);
    chk("abort_core_state", 256'(core_state), 256'd0);
    chk("abort_indice_clr", 256'(core_indice), 256'd0);
    e_v = 0; e_b = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clock);
      if (out_valid) e_v++;
      if (busy) e_b++;
    end
    chk("abort_no_output", 256'(e_v), 256'd0);
    chk("abort_no_accept", 256'(e_b), 256'd0);
    exp_q.push_back(ABC_H);
    send(abc, 1'b1);
    wait_valid(d);
    chk("post_abort_latency", 256'(d), 256'd133);
    @(posedge clock); #1;

    // asynchronous reset mid-ROUND
    send(abc, 1'b1);
    wait_round(10, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_core_state", 256'(core_state), 256'd0);
    chk("mid_rst_core_chunk", 256'(core_chunk), 256'd0);
    chk("mid_rst_core_flag", 256'(core_flag), 256'd0);
    chk("mid_rst_core_indice", 256'(core_indice), 256'd0);
    chk("mid_rst_core_rst_n", 256'(core_rst_n), 256'd0);
    chk("mid_rst_out_valid", 256'(out_valid), 256'd0);
    chk("mid_rst_out_hash", out_hash, 256'd0);
    chk("mid_rst_busy", 256'(busy), 256'd0);
    chk("mid_rst_in_ready", 256'(in_ready), 256'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("mid_rel_core_rst_n_low", 256'(core_rst_n), 256'd0);
    @(posedge clock); #1;
    chk("mid_rel_core_rst_n_high", 256'(core_rst_n), 256'd1);
    chk("mid_rel_idle", 256'(busy), 256'd0);

    chk("scoreboard_drained", 256'(exp_q.size()), 256'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sha256_sequencer.md
# sha256_sequencer

Control block that sequences the SHA-256 compression core and shares it between message-chunk producers and the hash consumer. It accepts 512-bit chunks over a valid/ready handshake and drives the core's 3-bit state code, chunk bus, phase flag (`flag`) and round index (`indice`). It returns the final 256-bit digest over a second valid/ready handshake. Multi-chunk messages are supported: hash-value initialisation happens only on the first chunk.

## Interface
- `ROUNDS`, 64, compression rounds per chunk; fixes the `indice` width at 6.
- `CHUNK_W`, 512, chunk width.
- `HASH_W`, 256, digest width.

- `clock`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `abort`  in  1  synchronous abort; sends the block back to IDLE.
- `in_valid`  in  1  chunk offered.
- `in_last`  in  1  offered chunk is the final chunk of its message.
- `in_chunk`  in  512  chunk data.
- `in_ready`  out  1  chunk is accepted when `in_valid && in_ready`.
- `core_state`  out  3  state code driven to the core.
- `core_chunk`  out  512  registered chunk driven to the core.
- `core_flag`  out  1  phase flag driven to the core.
- `core_indice`  out  6  round index driven to the core.
- `core_rst_n`  out  1  active-low synchronous reset for the core.
- `core_hash`  in  256  digest returned by the core.
- `out_valid`  out  1  digest available.
- `out_hash`  out  256  registered digest.
- `out_ready`  in  1  consumer accepts the digest.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states and the `core_state` code each one drives:
  - IDLE = 0.
  - INIT = 2.
  - LOAD = 4, with `flag` = 0.
  - EXPAND = 4, with `flag` = 1.
  - ROUND = 5.
  - FINAL = 6.
  - CHAIN = 3.
  - CAPTURE = 7.
  - DONE = 7.
- IDLE:
  - `in_ready` = 1.
  - On handshake: latch `in_chunk` into `core_chunk`, latch `in_last`, go to INIT.
- INIT: one cycle, then LOAD.
- LOAD: one cycle, then EXPAND.
- EXPAND: one cycle, then ROUND with `indice` = 0 and `flag` = 0.
- ROUND: two cycles per round.
  - First cycle `flag` = 0, second cycle `flag` = 1; `indice` is held across both.
  - After the `flag` = 1 cycle, `indice` increments.
  - After `indice` = 63 with `flag` = 1: go to FINAL if `last` is set, otherwise to CHAIN.
- CHAIN:
  - `in_ready` = 1 and `core_chunk` is held.
  - On handshake: latch the new chunk and `in_last`, go to LOAD. INIT is skipped so the core's chaining values are preserved.
- FINAL: one cycle; the core registers HASH on this edge.
- CAPTURE: one cycle; `out_hash` <= `core_hash`.
- DONE:
  - `out_valid` = 1.
  - On `out_ready`: go to IDLE and clear `out_valid`.
  - `out_hash` holds its value until the next capture.
- `in_ready` is 0 in every state except IDLE and CHAIN. `in_valid` in any other state is ignored.
- Abort: when `abort` = 1 in any state, the next state is IDLE.
  - `in_ready` is forced to 0 in that cycle, so a simultaneous handshake is not accepted.
  - `out_valid` is dropped.
  - The round counter is cleared.
- `core_rst_n` is 0 while `reset` is asserted and for one cycle after release; it is 1 otherwise.

## Timing
- Reset values:
  - state = IDLE.
  - `in_ready` = 1 after reset release; it is 0 while `reset` is asserted.
  - `core_state` = 0.
  - `core_chunk` = 0.
  - `core_flag` = 0.
  - `core_indice` = 0.
  - `core_rst_n` = 0.
  - `out_valid` = 0.
  - `out_hash` = 0.
  - `busy` = 0.
- Take the first-chunk handshake edge as T. The schedule is:
  - T+1: INIT.
  - T+2: LOAD.
  - T+3: EXPAND.
  - T+4 to T+131: ROUND (128 cycles).
  - T+132: FINAL.
  - T+133: CAPTURE.
  - From T+134: `out_valid` = 1.
- Continuation chunk (handshake in CHAIN at edge T): ROUND occupies T+3 to T+130; `out_valid` (if last) from T+133.
- Minimum turnaround is 1 cycle: a DONE handshake at edge E puts the block in IDLE, so `in_ready` = 1 in the cycle after E.
- The `indice` counter wraps 63 -> 0 only on leaving ROUND. It never wraps while still in ROUND.
- All outputs to the core are registered. `core_chunk` is stable from LOAD through the end of ROUND.

## Structure
- Shared package `sha256_pkg` holds:
  - `CORE_*` 3-bit state-code constants (0 to 7).
  - `ROUNDS`, `CHUNK_W` and `HASH_W`.
  - The FSM state enum.
- Sub-module `sha256_round_counter` holds the 6-bit `indice` and the phase bit.
  - Inputs: clear, enable.
  - Outputs: `indice`, `flag`, `last_round` (high when `indice` = 63 and `flag` = 1).

## Test plan
- Single chunk "abc" (padded block 0x61626380…0018), `out_ready` = 1:
  - `out_valid` at T+134.
  - `out_hash` = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Two-chunk 448-bit message "abcdbcdecdef…nopq":
  - INIT is seen once only.
  - CHAIN is entered between the chunks.
  - `out_hash` = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Round sequencing, checked cycle by cycle through ROUND:
  - `core_indice`/`core_flag` run (0,0) (0,1) (1,0) … (63,1).
  - `core_state` = 5 for exactly 128 cycles.
- Backpressure: hold `out_ready` = 0 for 20 cycles in DONE.
  - `out_valid` and `out_hash` stay stable.
  - `in_ready` = 0 throughout.
  - Released: IDLE on the next cycle.
- Abort:
  - `abort` at `indice` = 30 with `in_valid` = 1 gives IDLE next cycle with `in_ready` = 0 in the abort cycle and no output.
  - A following "abc" run then yields the correct digest.
- Reset mid-ROUND: assert `reset` asynchronously.
  - All outputs go to their reset values immediately.
  - `core_rst_n` stays 0 for one cycle after release.
